// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with fill level, almost-full/almost-empty thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise rdata is a registered read.
module sync_fifo_lvl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] L_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [AW:0] L_AF    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] L_AE    = (AW + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;

  assign w_full   = (r_level == L_DEPTH);
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;

  // Storage is not reset; reset still blocks a write at the same edge.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + L_ONE;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + L_ONE;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + L_ONE;
        2'b01:   r_level <= r_level - L_ONE;
        default: r_level <= r_level;
      endcase
      if (winc && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rinc && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = r_mem[r_rptr[AW-1:0]];
`else
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= r_mem[r_rptr[AW-1:0]];
    end
  end

  assign rdata = r_rdata;
`endif

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_level >= L_AF);
  assign ralmost_empty = (r_level <= L_AE);
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed testbench for sync_fifo_lvl (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2).
// Builds with or without FIFO_FWFT_EN; rdata checks follow the selected read mode.
module tb_sync_fifo_lvl;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo_lvl #(
    .WIDTH(8),
    .DEPTH(16),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .winc(winc),
    .wdata(wdata),
    .rinc(rinc),
    .rdata(rdata),
    .wfull(wfull),
    .rempty(rempty),
    .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL reset_rempty: got %b want 1", rempty); end
    n_cmp++; if (wfull !== 1'b0) begin n_bad++; $display("FAIL reset_wfull: got %b want 0", wfull); end
    n_cmp++; if (ralmost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ralmost_empty: got %b want 1", ralmost_empty); end
    n_cmp++; if (walmost_full !== 1'b0) begin n_bad++; $display("FAIL reset_walmost_full: got %b want 0", walmost_full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b want 0", underflow); end
`ifndef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
`endif
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      n_cmp++; if (level !== 5'(i)) begin n_bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); end
      n_cmp++; if (walmost_full !== (i >= 14)) begin n_bad++; $display("FAIL fill_walmost_full[%0d]: got %b want %b", i, walmost_full, (i >= 14)); end
      n_cmp++; if (ralmost_empty !== (i <= 2)) begin n_bad++; $display("FAIL fill_ralmost_empty[%0d]: got %b want %b", i, ralmost_empty, (i <= 2)); end
      n_cmp++; if (wfull !== (i == 16)) begin n_bad++; $display("FAIL fill_wfull[%0d]: got %b want %b", i, wfull, (i == 16)); end
    end
    winc = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow: got %b want 0", overflow); end
  endtask

  // Continues from a full FIFO holding 0x01..0x10.
  task automatic test_overflow();
    winc = 1'b1; wdata = 8'hFF;
    tick();
    winc = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level: got %0d want 16", level); end
    for (int i = 1; i <= 16; i++) begin
      rinc = 1'b1;
`ifdef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(i)) begin n_bad++; $display("FAIL ovf_readback[%0d]: got %h want %h", i, rdata, 8'(i)); end
`endif
      tick();
`ifndef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(i)) begin n_bad++; $display("FAIL ovf_readback[%0d]: got %h want %h", i, rdata, 8'(i)); end
`endif
    end
    rinc = 1'b0;
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained_rempty: got %b want 1", rempty); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL ovf_no_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL udf_flag: got %b want 1", underflow); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL udf_level: got %0d want 0", level); end
`ifndef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL udf_rdata: got %h want 00", rdata); end
`endif
    tick();
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL udf_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(8'h30 + i);
      tick();
    end
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
`ifdef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h30) begin n_bad++; $display("FAIL sim_full_rdata: got %h want 30", rdata); end
`endif
    tick();
    winc = 1'b0; rinc = 1'b0;
    n_cmp++; if (level !== 5'd15) begin n_bad++; $display("FAIL sim_full_level: got %0d want 15", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sim_full_overflow: got %b want 1", overflow); end
    n_cmp++; if (wfull !== 1'b0) begin n_bad++; $display("FAIL sim_full_wfull: got %b want 0", wfull); end
`ifndef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h30) begin n_bad++; $display("FAIL sim_full_rdata: got %h want 30", rdata); end
`endif

    do_reset();
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    tick();
    winc = 1'b0; rinc = 1'b0;
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL sim_empty_level: got %0d want 1", level); end
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL sim_empty_underflow: got %b want 1", underflow); end
    n_cmp++; if (rempty !== 1'b0) begin n_bad++; $display("FAIL sim_empty_rempty: got %b want 0", rempty); end
`ifdef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h77) begin n_bad++; $display("FAIL sim_empty_rdata: got %h want 77", rdata); end
`else
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL sim_empty_rdata: got %h want 00", rdata); end
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    n_cmp++; if (rdata !== 8'h77) begin n_bad++; $display("FAIL sim_empty_readback: got %h want 77", rdata); end
`endif
  endtask

  task automatic test_latency();
    do_reset();
    winc = 1'b1; wdata = 8'hA5;
    tick();
    winc = 1'b0;
    n_cmp++; if (rempty !== 1'b0) begin n_bad++; $display("FAIL lat_rempty_after_write: got %b want 0", rempty); end
`ifdef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL lat_fwft_rdata: got %h want a5", rdata); end
`else
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL lat_rdata_before_read: got %h want 00", rdata); end
`endif
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
`ifndef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL lat_rdata_after_read: got %h want a5", rdata); end
`endif
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL lat_rempty_after_read: got %b want 1", rempty); end
  endtask

  // 5 preloaded + 40 streamed writes carry both pointers past their 32-count wrap.
  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      winc = 1'b1; wdata = 8'(8'h40 + k);
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'(8'h45 + c);
`ifdef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(8'h40 + c)) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", c, rdata, 8'(8'h40 + c)); end
`endif
      tick();
`ifndef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(8'h40 + c)) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", c, rdata, 8'(8'h40 + c)); end
`endif
      n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL b2b_level[%0d]: got %0d want 5", c, level); end
    end
    winc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rinc = 1'b1;
`ifdef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(8'h68 + k)) begin n_bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, rdata, 8'(8'h68 + k)); end
`endif
      tick();
`ifndef FIFO_FWFT_EN
      n_cmp++; if (rdata !== 8'(8'h68 + k)) begin n_bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, rdata, 8'(8'h68 + k)); end
`endif
    end
    rinc = 1'b0;
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL b2b_rempty: got %b want 1", rempty); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL b2b_errors: got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(8'h90 + i);
      tick();
    end
    wdata = 8'hFF;
    tick();
    winc = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rinc = 1'b1;
      tick();
    end
    rinc = 1'b0;
    n_cmp++; if (level !== 5'd9) begin n_bad++; $display("FAIL rstmid_pre_level: got %0d want 9", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_overflow: got %b want 1", overflow); end
    rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h11;
    tick();
    rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
    n_cmp++; if (rempty !== 1'b1) begin n_bad++; $display("FAIL rstmid_rempty: got %b want 1", rempty); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_underflow: got %b want 0", underflow); end
`ifndef FIFO_FWFT_EN
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rstmid_rdata: got %h want 00", rdata); end
`endif
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    tick();
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO: one clock domain, arbitrary WIDTH/DEPTH, fill-level output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It buffers data between producer and consumer logic running on the same clock. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, walmost_full asserts when level ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, ralmost_empty asserts when level ≤ AE_LEVEL (0..DEPTH-1)
- AW, log2(DEPTH), derived localparam; not overridden

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- winc  in  1  write request
- wdata  in  WIDTH  write data, sampled with winc
- rinc  in  1  read request
- rdata  out  WIDTH  read data
- wfull  out  1  level == DEPTH
- rempty  out  1  level == 0
- walmost_full  out  1  level ≥ AF_LEVEL
- ralmost_empty  out  1  level ≤ AE_LEVEL
- level  out  AW+1  current entry count, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH register array; wptr/rptr are AW+1 bits, index with low AW bits, MSB used for wrap.
- level = wptr − rptr (modulo 2^(AW+1)); held in a register, updated from accepted ops.
- Write accepted iff winc && !wfull: mem[wptr[AW-1:0]] ← wdata, wptr+1.
- Read accepted iff rinc && !rempty: rptr+1.
- Flags are evaluated from the current registered state only. Simultaneous winc+rinc:
  - neither full nor empty: both accepted, level unchanged.
  - full: read accepted, write rejected, overflow set.
  - empty: write accepted, read rejected, underflow set.
- overflow/underflow set on rejected request; clear only on rst.
- Pointer wrap from 2·DEPTH−1 to 0 is natural binary rollover; no special case.
- Rejected requests do not alter memory, pointers, level or rdata.

## Timing
- Reset (rst high at edge): wptr=rptr=0, level=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0 (1 only if AF_LEVEL=0, disallowed), overflow=underflow=0, rdata=0. Memory contents undefined; not reset.
- rst mid-operation: takes priority over winc/rinc at same edge; all buffered data discarded.
- Write at edge N: level, rempty, almost flags reflect it after edge N (cycle N+1).
- Default read: rdata ← mem[rptr] registered at the edge accepting the read; valid cycle N+1; holds value until next accepted read.
- Write-to-read latency on empty FIFO: write edge N, rempty low in N+1, rinc in N+1 accepted at edge N+1, rdata valid N+2.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through; rdata = mem[rptr] continuously, valid whenever rempty=0; rinc acknowledges/pops current word; rdata shows next word in the cycle after the pop edge; rdata undefined while rempty=1 (reset value 0 not required).
- FIFO_FWFT_EN undefined: registered read as in Timing, rdata reset to 0.
- Flags, level, errors identical in both modes.

## Test plan
- Reset then 16 writes 0x01..0x10 (DEPTH=16, AF_LEVEL=14, AE_LEVEL=2) -> level 16, wfull=1, walmost_full from level 14, overflow=0.
- 17th write 0xFF while full -> rejected, overflow=1 sticky, subsequent reads return 0x01..0x10, never 0xFF.
- Read from empty after reset -> underflow=1, rdata stays 0x00, level 0.
- Write+read same cycle for 40 cycles with 5 entries preloaded -> level constant 5, data order preserved across pointer wrap.
- Full FIFO, winc+rinc together -> read accepted, write rejected, level 15, overflow=1; empty FIFO, both -> level 1, underflow=1.
- rst asserted with level 9 -> next cycle level 0, rempty=1, overflow=underflow=0; FWFT build: write 0xA5 to empty -> rdata=0xA5 in next cycle without rinc.
